// File: rtl/lamp_mode_scheduler.sv
// Car lamp front end: debounces four raw switches, arbitrates them into a lamp mode,
// and generates the animation tick, the door-light timeout and the 7-segment status codes.
module lamp_mode_scheduler #(
  parameter int DEB_CYCLES  = 500000,
  parameter int TICK_DIV    = 10000000,
  parameter int DOOR_CYCLES = 536870912
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_brake,
  input  logic       sw_door,
  output logic [2:0] mode,
  output logic       mode_chg,
  output logic       tick,
  output logic       door_timeout,
  output logic [6:0] seg_l,
  output logic [6:0] seg_r
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEFT     = 3'd1,
    RIGHT    = 3'd2,
    BRAKE    = 3'd3,
    HAZARD   = 3'd4,
    DOOR_ON  = 3'd5,
    DOOR_OFF = 3'd6
  } mode_t;

  localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int TICK_W = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0110000;
  localparam logic [6:0] SEG_ARROW = 7'b0111111;
  localparam logic [6:0] SEG_BRAKE = 7'b1110011;
  localparam logic [6:0] SEG_DOOR  = 7'b1111001;

  // Debounce: bit index 0 left, 1 right, 2 brake, 3 door.
  logic [3:0]       raw;
  logic [3:0]       deb;
  logic [DEB_W-1:0] deb_cnt [4];

  assign raw = {sw_door, sw_brake, sw_right, sw_left};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        deb_cnt[i] <= '0;
        deb[i]     <= 1'b0;
      end else if (raw[i] == deb[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        deb[i]     <= ~deb[i];
        deb_cnt[i] <= '0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  logic d_left, d_right, d_brake, d_door;

  assign d_left  = deb[0];
  assign d_right = deb[1];
  assign d_brake = deb[2];
  assign d_door  = deb[3];

  mode_t             mode_q;
  mode_t             next_mode;
  logic [TICK_W-1:0] tick_cnt;
  logic [DOOR_W-1:0] door_cnt;
  logic              door_expire;
  logic              changing;
  logic              ticking;

  assign door_expire = (mode_q == DOOR_ON) && (door_cnt == DOOR_LAST);
  assign changing    = (next_mode != mode_q);
  assign ticking     = (mode_q == LEFT) || (mode_q == RIGHT) ||
                       (mode_q == BRAKE) || (mode_q == HAZARD);

  // Fixed-priority arbiter; an open door masks brake and indicator requests.
  // NOTE: next_mode gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_mode = IDLE;
    if (d_door) begin
      if (mode_q == DOOR_OFF)     next_mode = DOOR_OFF;
      else if (mode_q == DOOR_ON) next_mode = door_expire ? DOOR_OFF : DOOR_ON;
      else                        next_mode = DOOR_ON;
    end else if (d_brake) begin
      next_mode = BRAKE;
    end else if (d_left && d_right) begin
      next_mode = HAZARD;
    end else if (d_left) begin
      next_mode = LEFT;
    end else if (d_right) begin
      next_mode = RIGHT;
    end
  end

  function automatic logic [13:0] seg_codes(input mode_t m);
    case (m)
      LEFT:              seg_codes = {SEG_ARROW, SEG_DASH};
      RIGHT:             seg_codes = {SEG_DASH, SEG_ARROW};
      BRAKE:             seg_codes = {SEG_BRAKE, SEG_BRAKE};
      HAZARD:            seg_codes = {SEG_ARROW, SEG_ARROW};
      DOOR_ON, DOOR_OFF: seg_codes = {SEG_DOOR, SEG_DOOR};
      default:           seg_codes = {SEG_DASH, SEG_DASH};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= IDLE;
      mode_chg     <= 1'b0;
      tick         <= 1'b0;
      door_timeout <= 1'b0;
      seg_l        <= SEG_DASH;
      seg_r        <= SEG_DASH;
      tick_cnt     <= '0;
      door_cnt     <= '0;
    end else begin
      mode_q         <= next_mode;
      mode_chg       <= changing;
      door_timeout   <= door_expire && (next_mode == DOOR_OFF);
      {seg_l, seg_r} <= seg_codes(next_mode);

      // A mode change wins over a coinciding wrap: counter restarts, no tick.
      if (changing || !ticking) begin
        tick_cnt <= '0;
        tick     <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        tick     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
        tick     <= 1'b0;
      end

      if ((mode_q == DOOR_ON) && !changing) door_cnt <= door_cnt + 1'b1;
      else                                  door_cnt <= '0;
    end
  end

  assign mode = mode_q;

endmodule
